// File: rtl/blink_scheduler.sv
// rtl/blink_scheduler.sv - debounced start/stop burst blink scheduler with three speed modes

module blink_scheduler_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] stable_cnt;

  // The counter only advances while the synchronized input disagrees with the
  // accepted level; one agreeing cycle starts the interval over.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != level) begin
        if (stable_cnt == LAST) begin
          level      <= sync2;
          stable_cnt <= '0;
          press      <= sync2;
        end else begin
          stable_cnt <= stable_cnt + CW'(1);
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

endmodule

module blink_scheduler #(
  parameter logic [21:0] LOW0            = 22'h1406F4,
  parameter logic [21:0] LOW1            = 22'h0D59F8,
  parameter logic [21:0] LOW2            = 22'h06ACFC,
  parameter int          BURST           = 3,
  parameter int          DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       speed_btn,
  input  logic       run_btn,
  output logic       led,
  output logic [2:0] mode,
  output logic       running,
  output logic       burst_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        speed_press;
  logic        run_press;
  logic [2:0]  mode_next;
  logic [2:0]  blinks;
  logic [21:0] low_len;
  logic [22:0] high_len;
  logic [23:0] gap_len;
  logic [23:0] phase_cnt;
  logic [23:0] phase_len;
  logic [23:0] phase_len_next;
  logic        phase_last;
  logic        led_next;
  logic        burst_done_next;

  blink_scheduler_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_speed_db (
    .clk   (clk),
    .reset (reset),
    .raw   (speed_btn),
    .press (speed_press)
  );

  blink_scheduler_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk   (clk),
    .reset (reset),
    .raw   (run_btn),
    .press (run_press)
  );

  // Durations come from the post-press mode so a simultaneous speed and run
  // press latches the new speed into the phase being entered.
  always_comb begin
    mode_next = speed_press ? {mode[1:0], mode[2]} : mode;
  end

  always_comb begin
    case (mode_next)
      3'b001:  low_len = LOW0;
      3'b010:  low_len = LOW1;
      default: low_len = LOW2;
    endcase
  end

  assign high_len   = {low_len, 1'b0};
  assign gap_len    = {low_len, 2'b00};
  assign phase_last = (phase_cnt == phase_len - 24'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (run_press) state_next = ST_HIGH;
      ST_HIGH: if (phase_last) state_next = ST_LOW;
      ST_LOW: begin
        if (phase_last) state_next = (blinks > 3'd1) ? ST_HIGH : ST_GAP;
      end
      ST_GAP:  if (phase_last) state_next = ST_HIGH;
      default: state_next = ST_IDLE;
    endcase
    if (state != ST_IDLE && run_press) state_next = ST_IDLE;
  end

  always_comb begin
    led_next        = (state_next == ST_HIGH);
    burst_done_next = (state == ST_LOW) && (state_next == ST_GAP);
    case (state_next)
      ST_HIGH: phase_len_next = {1'b0, high_len};
      ST_LOW:  phase_len_next = {2'b00, low_len};
      ST_GAP:  phase_len_next = gap_len;
      default: phase_len_next = '0;
    endcase
  end

  assign running = (state != ST_IDLE);

  // No state ever transitions to itself, so any change of state is an entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode       <= 3'b100;
      phase_cnt  <= '0;
      phase_len  <= '0;
      blinks     <= '0;
      led        <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      mode       <= mode_next;
      led        <= led_next;
      burst_done <= burst_done_next;
      if (state_next != state) begin
        phase_cnt <= '0;
        phase_len <= phase_len_next;
      end else if (state != ST_IDLE) begin
        phase_cnt <= phase_cnt + 24'd1;
      end
      if (state_next == ST_HIGH && (state == ST_IDLE || state == ST_GAP)) begin
        blinks <= 3'(BURST);
      end else if (state == ST_LOW && state_next == ST_HIGH) begin
        blinks <= blinks - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_blink_scheduler.sv
// tb/tb_blink_scheduler.sv - directed self-checking bench for blink_scheduler

module tb_blink_scheduler;

  logic       clk;
  logic       reset;
  logic       speed_btn;
  logic       run_btn;
  logic       led;
  logic [2:0] mode;
  logic       running;
  logic       burst_done;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  blink_scheduler #(
    .LOW0            (22'd12),
    .LOW1            (22'd8),
    .LOW2            (22'd4),
    .BURST           (3),
    .DEBOUNCE_CYCLES (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .speed_btn  (speed_btn),
    .run_btn    (run_btn),
    .led        (led),
    .mode       (mode),
    .running    (running),
    .burst_done (burst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    speed_btn = 1'b0;
    run_btn   = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Raw press held from the current cycle k: pulse in k+5, new state visible in k+6.
  task automatic press_run();
    run_btn = 1'b1;
    repeat (6) tick();
    run_btn = 1'b0;
  endtask

  task automatic press_speed();
    speed_btn = 1'b1;
    repeat (6) tick();
    speed_btn = 1'b0;
    repeat (6) tick();
  endtask

  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (led === lvl && n < 400) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; speed_btn = 1'b0; run_btn = 1'b0;
    tick();
    chk_cnt++; if (led !== 1'b0) $display("FAIL reset_led: got %b expected 0", led); else pass_cnt++;
    chk_cnt++; if (mode !== 3'b100) $display("FAIL reset_mode: got %b expected 100", mode); else pass_cnt++;
    chk_cnt++; if (running !== 1'b0) $display("FAIL reset_running: got %b expected 0", running); else pass_cnt++;
    chk_cnt++; if (burst_done !== 1'b0) $display("FAIL reset_burst_done: got %b expected 0", burst_done); else pass_cnt++;
    reset = 1'b1;
    repeat (4) tick();
    chk_cnt++; if (running !== 1'b0) $display("FAIL idle_running: got %b expected 0", running); else pass_cnt++;
  endtask

  task automatic test_debounce();
    do_reset();
    run_btn = 1'b1; tick();
    run_btn = 1'b0; tick();
    run_btn = 1'b1;
    repeat (5) tick();
    chk_cnt++; if (running !== 1'b0) $display("FAIL db_early: got running %b expected 0", running); else pass_cnt++;
    tick();
    chk_cnt++; if (running !== 1'b1) $display("FAIL db_start: got running %b expected 1", running); else pass_cnt++;
    chk_cnt++; if (led !== 1'b1) $display("FAIL db_led: got %b expected 1", led); else pass_cnt++;
    repeat (10) tick();
    chk_cnt++; if (running !== 1'b1) $display("FAIL db_hold: got running %b expected 1", running); else pass_cnt++;
    run_btn = 1'b0;
    repeat (12) tick();
    chk_cnt++; if (running !== 1'b1) $display("FAIL db_release: got running %b expected 1", running); else pass_cnt++;
  endtask

  task automatic test_fast_burst();
    int n;
    do_reset();
    press_run();
    chk_cnt++; if (running !== 1'b1) $display("FAIL fb_running: got %b expected 1", running); else pass_cnt++;
    for (int b = 0; b < 3; b++) begin
      run_len(1'b1, n);
      chk_cnt++; if (n != 8) $display("FAIL fb_high%0d: got %0d cycles expected 8", b, n); else pass_cnt++;
      if (b < 2) begin
        run_len(1'b0, n);
        chk_cnt++; if (n != 4) $display("FAIL fb_low%0d: got %0d cycles expected 4", b, n); else pass_cnt++;
      end
    end
    repeat (3) tick();
    chk_cnt++; if (burst_done !== 1'b0) $display("FAIL fb_done_early: got %b expected 0", burst_done); else pass_cnt++;
    tick();
    chk_cnt++; if (burst_done !== 1'b1) $display("FAIL fb_done_pulse: got %b expected 1", burst_done); else pass_cnt++;
    chk_cnt++; if (led !== 1'b0) $display("FAIL fb_done_led: got %b expected 0", led); else pass_cnt++;
    tick();
    chk_cnt++; if (burst_done !== 1'b0) $display("FAIL fb_done_width: got %b expected 0", burst_done); else pass_cnt++;
    run_len(1'b0, n);
    chk_cnt++; if (n != 15) $display("FAIL fb_gap_rest: got %0d cycles expected 15", n); else pass_cnt++;
    run_len(1'b1, n);
    chk_cnt++; if (n != 8) $display("FAIL fb_repeat_high: got %0d cycles expected 8", n); else pass_cnt++;
    chk_cnt++; if (running !== 1'b1) $display("FAIL fb_repeat_running: got %b expected 1", running); else pass_cnt++;
  endtask

  task automatic test_speed_rotation();
    int n;
    do_reset();
    press_speed();
    chk_cnt++; if (mode !== 3'b001) $display("FAIL rot_1: got %b expected 001", mode); else pass_cnt++;
    press_speed();
    chk_cnt++; if (mode !== 3'b010) $display("FAIL rot_2: got %b expected 010", mode); else pass_cnt++;
    press_speed();
    chk_cnt++; if (mode !== 3'b100) $display("FAIL rot_3: got %b expected 100", mode); else pass_cnt++;
    press_speed();
    press_run();
    for (int b = 0; b < 3; b++) begin
      run_len(1'b1, n);
      chk_cnt++; if (n != 24) $display("FAIL slow_high%0d: got %0d cycles expected 24", b, n); else pass_cnt++;
      run_len(1'b0, n);
      chk_cnt++; if (n != ((b < 2) ? 12 : 60)) $display("FAIL slow_low%0d: got %0d cycles expected %0d", b, n, (b < 2) ? 12 : 60); else pass_cnt++;
    end
  endtask

  task automatic test_mid_phase_speed();
    int n;
    do_reset();
    run_btn = 1'b1;
    repeat (4) tick();
    speed_btn = 1'b1;
    repeat (2) tick();
    run_btn = 1'b0;
    chk_cnt++; if (running !== 1'b1) $display("FAIL mid_running: got %b expected 1", running); else pass_cnt++;
    run_len(1'b1, n);
    speed_btn = 1'b0;
    chk_cnt++; if (n != 8) $display("FAIL mid_high: got %0d cycles expected 8", n); else pass_cnt++;
    chk_cnt++; if (mode !== 3'b001) $display("FAIL mid_mode: got %b expected 001", mode); else pass_cnt++;
    run_len(1'b0, n);
    chk_cnt++; if (n != 12) $display("FAIL mid_low: got %0d cycles expected 12", n); else pass_cnt++;
  endtask

  task automatic test_stop();
    int n;
    do_reset();
    press_run();
    repeat (35) tick();
    run_btn = 1'b1;
    repeat (5) tick();
    chk_cnt++; if (running !== 1'b1) $display("FAIL stop_gap_before: got running %b expected 1", running); else pass_cnt++;
    tick();
    chk_cnt++; if (running !== 1'b0) $display("FAIL stop_gap_running: got %b expected 0", running); else pass_cnt++;
    chk_cnt++; if (led !== 1'b0) $display("FAIL stop_gap_led: got %b expected 0", led); else pass_cnt++;
    chk_cnt++; if (burst_done !== 1'b0) $display("FAIL stop_gap_done: got %b expected 0", burst_done); else pass_cnt++;
    run_btn = 1'b0;
    repeat (10) tick();
    chk_cnt++; if (running !== 1'b0) $display("FAIL stop_gap_stays: got running %b expected 0", running); else pass_cnt++;
    press_run();
    run_len(1'b1, n);
    chk_cnt++; if (n != 8) $display("FAIL restart_high0: got %0d cycles expected 8", n); else pass_cnt++;
    run_len(1'b0, n);
    chk_cnt++; if (n != 4) $display("FAIL restart_low0: got %0d cycles expected 4", n); else pass_cnt++;
    run_btn = 1'b1;
    repeat (5) tick();
    chk_cnt++; if (led !== 1'b1) $display("FAIL stop_high_before: got led %b expected 1", led); else pass_cnt++;
    tick();
    chk_cnt++; if (running !== 1'b0) $display("FAIL stop_high_running: got %b expected 0", running); else pass_cnt++;
    chk_cnt++; if (led !== 1'b0) $display("FAIL stop_high_led: got %b expected 0", led); else pass_cnt++;
    chk_cnt++; if (burst_done !== 1'b0) $display("FAIL stop_high_done: got %b expected 0", burst_done); else pass_cnt++;
    run_btn = 1'b0;
    repeat (10) tick();
    press_run();
    for (int b = 0; b < 3; b++) begin
      run_len(1'b1, n);
      chk_cnt++; if (n != 8) $display("FAIL full_high%0d: got %0d cycles expected 8", b, n); else pass_cnt++;
      run_len(1'b0, n);
      chk_cnt++; if (n != ((b < 2) ? 4 : 20)) $display("FAIL full_low%0d: got %0d cycles expected %0d", b, n, (b < 2) ? 4 : 20); else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    press_speed();
    press_run();
    repeat (2) tick();
    run_btn = 1'b1;
    repeat (3) tick();
    chk_cnt++; if (led !== 1'b1) $display("FAIL ar_led_before: got %b expected 1", led); else pass_cnt++;
    #2;
    reset = 1'b0;
    #1;
    chk_cnt++; if (led !== 1'b0) $display("FAIL ar_led: got %b expected 0", led); else pass_cnt++;
    chk_cnt++; if (mode !== 3'b100) $display("FAIL ar_mode: got %b expected 100", mode); else pass_cnt++;
    chk_cnt++; if (running !== 1'b0) $display("FAIL ar_running: got %b expected 0", running); else pass_cnt++;
    tick();
    reset = 1'b1;
    repeat (5) tick();
    chk_cnt++; if (running !== 1'b0) $display("FAIL ar_held_early: got running %b expected 0", running); else pass_cnt++;
    tick();
    chk_cnt++; if (running !== 1'b1) $display("FAIL ar_held_start: got running %b expected 1", running); else pass_cnt++;
    run_btn = 1'b0;
    run_len(1'b1, n);
    chk_cnt++; if (n != 8) $display("FAIL ar_high: got %0d cycles expected 8", n); else pass_cnt++;
    run_len(1'b0, n);
    chk_cnt++; if (n != 4) $display("FAIL ar_low: got %0d cycles expected 4", n); else pass_cnt++;
  endtask

  initial begin
    reset     = 1'b0;
    speed_btn = 1'b0;
    run_btn   = 1'b0;
    test_reset();
    test_debounce();
    test_fast_burst();
    test_speed_rotation();
    test_mid_phase_speed();
    test_stop();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
